// File: rtl/mod_split_func_pkg.sv
// Shared types and arithmetic helpers for the split function-call pipeline.
// Helpers operate on a wide carrier type so any lane width up to MAX_W-1 bits
// can share them; callers narrow the result with a size cast.
package mod_split_func_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  // Unsigned add of two w-bit operands held in a wide carrier. The sum is
  // formed one bit wider than the lane, then either wrapped modulo 2^w or
  // clamped to 2^w-1 when sat is set.
  function automatic wide_t add_sat(input wide_t p, input wide_t q,
                                    input int unsigned w, input logic sat);
    logic [MAX_W:0] sum_v;
    logic [MAX_W:0] max_v;
    wide_t          res_v;
    sum_v = {1'b0, p} + {1'b0, q};
    max_v = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
    if (sum_v > max_v) begin
      if (sat) begin
        res_v = max_v[MAX_W-1:0];
      end else begin
        res_v = sum_v[MAX_W-1:0] & max_v[MAX_W-1:0];
      end
    end else begin
      res_v = sum_v[MAX_W-1:0];
    end
    return res_v;
  endfunction

  // Number of set bits in v.
  function automatic int unsigned popcount(input wide_t v);
    int unsigned cnt_v;
    cnt_v = 32'd0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt_v = cnt_v + {31'd0, v[i]};
    end
    return cnt_v;
  endfunction

endpackage

// File: rtl/mod_split_func_lane.sv
// Combinational per-lane compute: a = f(x), b = override or increment, m = override taken.
// f(v) = v + OFFSET; the override path applies BOOST first, reducing after each add.
module mod_split_func_lane
  import mod_split_func_pkg::*;
#(
  parameter int W      = 8,
  parameter int OFFSET = 5,
  parameter int BOOST  = 10,
  parameter int THRESH = 50,
  parameter int SAT    = 0
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         m
);

  localparam logic [W-1:0] OFFSET_L = W'(OFFSET);
  localparam logic [W-1:0] BOOST_L  = W'(BOOST);
  localparam logic         SAT_L    = (SAT != 0);

  logic [W-1:0] boosted_s;

  // Lane arithmetic; threshold compare is unsigned and strict.
  always_comb begin
    boosted_s = W'(add_sat(wide_t'(x), wide_t'(BOOST_L), W, SAT_L));
    a         = W'(add_sat(wide_t'(x), wide_t'(OFFSET_L), W, SAT_L));
    m         = (wide_t'(x) > wide_t'(THRESH));
    if (m) begin
      b = W'(add_sat(wide_t'(boosted_s), wide_t'(OFFSET_L), W, SAT_L));
    end else begin
      b = W'(add_sat(wide_t'(x), wide_t'({{(W-1){1'b0}}, 1'b1}), W, SAT_L));
    end
  end

endmodule

// File: rtl/mod_split_func_pipe.sv
// N-lane two-stage pipeline around mod_split_func_lane with valid/ready
// handshake, per-beat override mask and a saturating override counter.
module mod_split_func_pipe
  import mod_split_func_pkg::*;
#(
  parameter int W      = 8,
  parameter int N      = 2,
  parameter int OFFSET = 5,
  parameter int BOOST  = 10,
  parameter int THRESH = 50,
  parameter int SAT    = 0,
  parameter int CW     = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] data_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_a,
  output logic [N*W-1:0] out_b,
  output logic [N-1:0]   override_mask,
  output logic [CW-1:0]  override_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [N*W-1:0] a1_s;
  logic [N*W-1:0] b1_s;
  logic [N-1:0]   m1_s;

  logic           s1_valid_r;
  logic [N*W-1:0] s1_a_r;
  logic [N*W-1:0] s1_b_r;
  logic [N-1:0]   s1_m_r;

  logic           s2_valid_r;
  logic [N*W-1:0] s2_a_r;
  logic [N*W-1:0] s2_b_r;
  logic [N-1:0]   s2_m_r;

  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_nxt_s;
  logic [CW:0]    count_sum_s;

  logic           s2_adv_s;
  logic           load_s1_s;
  logic           drain_s;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mod_split_func_lane #(
      .W      (W),
      .OFFSET (OFFSET),
      .BOOST  (BOOST),
      .THRESH (THRESH),
      .SAT    (SAT)
    ) u_lane (
      .x (data_in[i*W +: W]),
      .a (a1_s[i*W +: W]),
      .b (b1_s[i*W +: W]),
      .m (m1_s[i])
    );
  end

  // Handshake: stage 2 takes stage 1 whenever it is empty or being drained,
  // and stage 1 accepts whenever it is empty or moving on this cycle.
  always_comb begin
    s2_adv_s  = s1_valid_r && (!s2_valid_r || out_ready);
    in_ready  = !s1_valid_r || s2_adv_s;
    load_s1_s = in_valid && in_ready;
    drain_s   = s2_valid_r && out_ready;
  end

  // Next override count: add this beat's override lanes, clamp at all-ones.
  always_comb begin
    count_sum_s = {1'b0, count_r} + (CW+1)'(popcount(wide_t'(s2_m_r)));
    if (count_sum_s > {1'b0, CNT_MAX}) begin
      count_nxt_s = CNT_MAX;
    end else begin
      count_nxt_s = count_sum_s[CW-1:0];
    end
  end

  // Stage 1: capture a new beat, or empty out once its beat moves to stage 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_m_r     <= '0;
    end else if (load_s1_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= a1_s;
      s1_b_r     <= b1_s;
      s1_m_r     <= m1_s;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 (output registers): load on advance, hold while stalled, clear on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_a_r     <= '0;
      s2_b_r     <= '0;
      s2_m_r     <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_a_r     <= s1_a_r;
      s2_b_r     <= s1_b_r;
      s2_m_r     <= s1_m_r;
    end else if (drain_s) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Override counter: accumulate on each delivered beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (drain_s) begin
      count_r <= count_nxt_s;
    end
  end

  assign out_valid      = s2_valid_r;
  assign out_a          = s2_a_r;
  assign out_b          = s2_b_r;
  assign override_mask  = s2_m_r;
  assign override_count = count_r;

endmodule

// File: tb/tb_mod_split_func_pipe.sv
// Scoreboard bench: four instances (wrap/clamp, THRESH 50/255, CW 16/3) share
// one stimulus stream and stay handshake-locked; expectations come from a
// reference model evaluated when a beat is accepted.
module tb_mod_split_func_pipe;

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][1:0]  m;
  } exp_t;

  localparam int TH   [4] = '{50, 50, 255, 255};
  localparam int SATV [4] = '{0, 1, 0, 1};
  localparam int CMAX [4] = '{65535, 7, 65535, 65535};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        out_ready = 1'b0;

  logic        in_ready  [4];
  logic        out_valid [4];
  logic [15:0] out_a     [4];
  logic [15:0] out_b     [4];
  logic [1:0]  mask      [4];
  logic [15:0] cnt       [4];
  logic [15:0] cnt0, cnt2, cnt3;
  logic [2:0]  cnt1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   cnt_exp [4];
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  mod_split_func_pipe #(.SAT(0), .THRESH(50), .CW(16)) d0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]), .data_in(data_in),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_a(out_a[0]), .out_b(out_b[0]),
    .override_mask(mask[0]), .override_count(cnt0));
  mod_split_func_pipe #(.SAT(1), .THRESH(50), .CW(3)) d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]), .data_in(data_in),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_a(out_a[1]), .out_b(out_b[1]),
    .override_mask(mask[1]), .override_count(cnt1));
  mod_split_func_pipe #(.SAT(0), .THRESH(255), .CW(16)) d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]), .data_in(data_in),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_a(out_a[2]), .out_b(out_b[2]),
    .override_mask(mask[2]), .override_count(cnt2));
  mod_split_func_pipe #(.SAT(1), .THRESH(255), .CW(16)) d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[3]), .data_in(data_in),
    .out_valid(out_valid[3]), .out_ready(out_ready), .out_a(out_a[3]), .out_b(out_b[3]),
    .override_mask(mask[3]), .override_count(cnt3));

  assign cnt[0] = cnt0;
  assign cnt[1] = {13'd0, cnt1};
  assign cnt[2] = cnt2;
  assign cnt[3] = cnt3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_add(input int p, input int q2, input int sat);
    int s;
    s = p + q2;
    if (s > 255) return (sat != 0) ? 255 : s - 256;
    return s;
  endfunction

  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    int x, av, bv, s;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      s = SATV[i];
      for (int l = 0; l < 2; l++) begin
        x  = int'(d[l*8 +: 8]);
        av = m_add(x, 5, s);
        if (x > TH[i]) begin
          bv = m_add(m_add(x, 10, s), 5, s);
          e.m[i][l] = 1'b1;
        end else begin
          bv = m_add(x, 1, s);
        end
        e.a[i][l*8 +: 8] = 8'(av);
        e.b[i][l*8 +: 8] = 8'(bv);
      end
    end
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   nc;
    if (!reset && mon_en) begin
      for (int i = 0; i < 4; i++) chk($sformatf("count%0d", i), cnt[i], cnt_exp[i]);
      chk("in_ready", in_ready[0], !(q.size() == 2 && !out_ready));
      if (q.size() == 0) begin
        chk("no_spurious_valid", out_valid[0], 1'b0);
      end else if (out_valid[0]) begin
        e = q[0];
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("valid%0d", i), out_valid[i], 1'b1);
          chk($sformatf("out_a%0d", i), out_a[i], e.a[i]);
          chk($sformatf("out_b%0d", i), out_b[i], e.b[i]);
          chk($sformatf("mask%0d", i), mask[i], e.m[i]);
        end
        if (out_ready) begin
          void'(q.pop_front());
          for (int i = 0; i < 4; i++) begin
            nc = cnt_exp[i] + $countones(e.m[i]);
            cnt_exp[i] = (nc > CMAX[i]) ? CMAX[i] : nc;
          end
        end
      end
      if (in_valid && in_ready[0]) q.push_back(model(data_in));
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, out_valid[i], 1'b0);
      chk({tag, "_a"}, out_a[i], 16'd0);
      chk({tag, "_b"}, out_b[i], 16'd0);
      chk({tag, "_mask"}, mask[i], 2'd0);
      chk({tag, "_cnt"}, cnt[i], 16'd0);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 4; i++) cnt_exp[i] = 0;
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit rdy, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    data_in   = d;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready[0];
  endtask

  task automatic drain();
    bit acc;
    int k;
    k = 0;
    while (q.size() > 0 && k < 50) begin
      cycle(1'b0, 16'd0, 1'b1, acc);
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [15:0] gen(input int dmode);
    logic [7:0] edges [10];
    edges = '{8'd0, 8'd1, 8'd50, 8'd51, 8'd244, 8'd245, 8'd250, 8'd252, 8'd254, 8'd255};
    case (dmode)
      1:       return {8'($urandom_range(51, 255)), 8'($urandom_range(51, 255))};
      2:       return {edges[$urandom_range(0, 9)], edges[$urandom_range(0, 9)]};
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic bit rdy_of(input int rmode, input int c);
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    case (rmode)
      1:       return pat[c % 5];
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_stream(input int n, input int rmode, input int dmode);
    int sent, c;
    bit acc;
    logic [15:0] d;
    sent = 0;
    c = 0;
    d = gen(dmode);
    while (sent < n && c < 2000) begin
      cycle(1'b1, d, rdy_of(rmode, c), acc);
      c++;
      if (acc) begin
        sent++;
        d = gen(dmode);
      end
    end
    if (sent < n) chk("stream_timeout", sent, n);
    drain();
  endtask

  // One beat into an empty pipe: checks the two-edge latency and d0/d1 values.
  task automatic lat_beat(input string tag, input logic [15:0] d,
                          input logic [15:0] ea0, input logic [15:0] eb0, input logic [1:0] em,
                          input logic [15:0] ea1, input logic [15:0] eb1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    data_in = d;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, in_ready[0], 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_k"}, out_valid[0], 1'b0);
    @(negedge clk);
    chk({tag, "_lat_k1"}, out_valid[0], 1'b1);
    chk({tag, "_a0"}, out_a[0], ea0);
    chk({tag, "_b0"}, out_b[0], eb0);
    chk({tag, "_m0"}, mask[0], em);
    chk({tag, "_a1"}, out_a[1], ea1);
    chk({tag, "_b1"}, out_b[1], eb1);
    drain();
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    clear_model();
    chk_zero("rst_pulse");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    clear_model();
    #12;
    chk_zero("por");
    chk("por_in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready[0], 1'b1);
    mon_en = 1'b1;

    lat_beat("basic", {8'd50, 8'd20}, {8'd55, 8'd25}, {8'd51, 8'd21}, 2'b00,
             {8'd55, 8'd25}, {8'd51, 8'd21});
    chk("basic_count", cnt[0], 16'd0);
    lat_beat("ovr", {8'd200, 8'd51}, {8'd205, 8'd56}, {8'd215, 8'd66}, 2'b11,
             {8'd205, 8'd56}, {8'd215, 8'd66});
    chk("ovr_count", cnt[0], 16'd2);
    lat_beat("wrap", {8'd255, 8'd252}, {8'd4, 8'd1}, {8'd14, 8'd11}, 2'b11,
             {8'd255, 8'd255}, {8'd255, 8'd255});

    run_stream(5, 1, 0);
    run_stream(12, 1, 2);

    reset_pulse();
    run_stream(5, 0, 1);
    chk("cnt_sat_cw3", cnt[1], 16'd7);
    chk("cnt_cw16", cnt[0], 16'd10);

    run_stream(30, 2, 0);

    // Fill both stages, then reset asynchronously between edges.
    cycle(1'b1, 16'h1234, 1'b0, acc);
    chk("fill1", acc, 1'b1);
    cycle(1'b1, 16'h5678, 1'b0, acc);
    chk("fill2", acc, 1'b1);
    cycle(1'b1, 16'h9abc, 1'b0, acc);
    chk("full_blocks", acc, 1'b0);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_zero("mid_rst");
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat_beat("after_rst", {8'd50, 8'd20}, {8'd55, 8'd25}, {8'd51, 8'd21}, 2'b00,
             {8'd55, 8'd25}, {8'd51, 8'd21});
    chk("after_rst_cnt", cnt[0], 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_split_func_pipe.md
Name: mod_split_func_pipe

Overview:
- N-lane, parametrised successor of the split function-call register block.
- Per lane, two results per input word:
  - A = f(x).
  - B = x + 1 by default, overridden by f(x + BOOST) when x > THRESH.
- Two-stage registered pipeline with valid/ready handshake, optional saturating arithmetic, and an override mask and counter.
- Sits between a streaming source and downstream consumers in the V3Split test datapath.

Parameters:
- W, 8, lane data width in bits (>=2).
- N, 2, number of lanes.
- OFFSET, 5, constant added by f(v) = v + OFFSET.
- BOOST, 10, pre-offset added to x on the override path.
- THRESH, 50, override threshold; strict greater-than, unsigned.
- SAT, 0, 0 = wrap modulo 2^W, 1 = clamp at 2^W-1.
- CW, 16, width of override_count.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- data_in  input  N*W  lane i at bits [i*W +: W].
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_a  output  N*W  per-lane f(x).
- out_b  output  N*W  per-lane B result.
- override_mask  output  N  bit i = lane i took the override path for the current output beat.
- override_count  output  CW  saturating count of override lanes delivered.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - s1_valid = s2_valid = 0.
  - out_a, out_b, override_mask, override_count all 0.
  - out_valid = 0; in_ready = 1 in the cycle after reset deasserts.
- Stage 1 captures on in_valid && in_ready:
  - Per lane: a1 = f(x); b1 = (x > THRESH) ? f(add(x, BOOST)) : add(x, 1); m1 = (x > THRESH).
- Stage 2 (output registers) loads from stage 1 when s2_adv.
  - out_valid = s2_valid.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_adv (combinational; no bubbles at full rate).
  - s2_valid clears when out_ready && s2_valid && !s2_adv.
- Latency: a beat accepted at edge k appears on out_* after edge k+1 when unstalled.
- Throughput: 1 beat/cycle.
- Stall: while out_valid && !out_ready, out_a/out_b/override_mask hold stable.
  - Stage 1 holds its beat; in_ready=0 once stage 1 is also full.
- Arithmetic:
  - add(p, q) is a (W+1)-bit sum, then wrap (SAT=0) or clamp to 2^W-1 (SAT=1).
  - The override path applies add twice, reducing after each step.
  - All comparisons are unsigned.
- override_count:
  - On each out_valid && out_ready, adds popcount(override_mask).
  - Saturates at 2^CW-1; never wraps.
- Simultaneous capture into stage 1 and drain of stage 2 in one cycle is legal and must not drop or duplicate beats.
- Reset mid-operation: in-flight beats are discarded and the count is cleared; no partial beat is emitted.
- Data bits while out_valid=0 are don't-care for checking, but must be reset to 0.

Decomposition:
- Package mod_split_func_pkg:
  - lane_t typedef (logic [W-1:0] via a parametrised struct, or passed as a parameter).
  - add_sat function (wrap/clamp, selected by SAT).
  - popcount function.
- One sub-module, mod_split_func_lane: purely combinational per-lane compute of a1/b1/m1, instantiated N times with a generate loop.
- The top level holds the pipeline registers, handshake and counter.

Test Plan (W=8, N=2, OFFSET=5, BOOST=10, THRESH=50 unless noted):
- Basic path: lanes {20, 50}, out_ready=1 -> two cycles later out_a={25, 55}, out_b={21, 51}, mask=00, count stays 0.
- Override: lanes {51, 200} -> out_a={56, 205}, out_b={66, 215}, mask=11, count=2 after the handshake.
- Wrap vs saturate: lane 252 with SAT=0 -> a=1, b=11; with SAT=1 -> a=255, b=255. Lane 255 non-override is impossible (255 > 50), so also test THRESH=255: x=255 -> b=0 (SAT=0) or 255 (SAT=1).
- Backpressure: stream 5 beats with out_ready toggling 1,0,0,1,1,... -> outputs in order, no loss or duplication, outputs stable while stalled, in_ready=0 when both stages are full.
- Counter saturation: CW=3, send 5 beats with both lanes overriding -> count 2,4,6,7,7.
- Async reset mid-stream with both stages full -> all outputs 0 immediately (before the next clk edge), and the first post-reset beat emerges with correct 2-cycle latency.
